// File: rtl/gshare_pht.sv
// Gshare pattern history table: valid bits and saturating counters with a global history register.
// Define PHT_GSHARE_EN to hash the lookup index with the history; otherwise index_i is used directly.
module gshare_pht #(
  parameter int INDEX_WIDTH = 4,
  parameter int CTR_WIDTH   = 2,
  parameter int HIST_WIDTH  = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic                   is_branch_i,
  input  logic [INDEX_WIDTH-1:0] index_i,
  input  logic                   update_en_i,
  input  logic                   last_taken_i,
  input  logic                   fallback_i,
  output logic                   taken_o,
  output logic                   hit_o,
  output logic [HIST_WIDTH-1:0]  ghr_o
);

  localparam int SIZE = 2 ** INDEX_WIDTH;
  localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;
  localparam logic [CTR_WIDTH-1:0] WEAK_T  = {1'b1, {(CTR_WIDTH-1){1'b0}}};
  localparam logic [CTR_WIDTH-1:0] WEAK_NT = {1'b0, {(CTR_WIDTH-1){1'b1}}};

  logic [CTR_WIDTH-1:0]   ctr_q [SIZE];
  logic [SIZE-1:0]        valid_q;
  logic [INDEX_WIDTH-1:0] last_q;
  logic [HIST_WIDTH-1:0]  ghr_q;

  logic [INDEX_WIDTH-1:0] lookup_idx;
  logic [HIST_WIDTH-1:0]  ghr_next;
  logic [CTR_WIDTH-1:0]   upd_ctr;
  logic                   alloc;
  logic                   upd;

`ifdef PHT_GSHARE_EN
  logic [INDEX_WIDTH-1:0] ghr_ext;

  always_comb begin
    ghr_ext = '0;
    ghr_ext[HIST_WIDTH-1:0] = ghr_q;
  end

  assign lookup_idx = index_i ^ ghr_ext;
`else
  assign lookup_idx = index_i;
`endif

  generate
    if (HIST_WIDTH > 1) begin : g_hist_multi
      assign ghr_next = {ghr_q[HIST_WIDTH-2:0], last_taken_i};
    end else begin : g_hist_single
      assign ghr_next = last_taken_i;
    end
  endgenerate

  assign hit_o   = valid_q[lookup_idx];
  assign taken_o = hit_o ? ctr_q[lookup_idx][CTR_WIDTH-1] : fallback_i;
  assign ghr_o   = ghr_q;

  assign alloc = en_i & is_branch_i & ~hit_o;
  assign upd   = en_i & update_en_i;

  // Saturating step computed from the stored value at the previous lookup's entry.
  always_comb begin
    upd_ctr = ctr_q[last_q];
    if (last_taken_i) begin
      if (ctr_q[last_q] != CTR_MAX) upd_ctr = ctr_q[last_q] + 1'b1;
    end else begin
      if (ctr_q[last_q] != '0) upd_ctr = ctr_q[last_q] - 1'b1;
    end
  end

  // The update write comes after the allocation write so it wins on a same-entry collision,
  // while the allocation still sets the valid bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < SIZE; i++) ctr_q[i] <= '0;
      valid_q <= '0;
      last_q  <= '0;
      ghr_q   <= '0;
    end else if (en_i) begin
      last_q <= lookup_idx;
      if (alloc) begin
        valid_q[lookup_idx] <= 1'b1;
        ctr_q[lookup_idx]   <= fallback_i ? WEAK_T : WEAK_NT;
      end
      if (upd) begin
        ctr_q[last_q] <= upd_ctr;
        ghr_q         <= ghr_next;
      end
    end
  end

endmodule

// File: tb/tb_gshare_pht.sv
// Self-checking bench for gshare_pht: directed scenarios plus randomized traffic against a table model.
module tb_gshare_pht;

  localparam int IW   = 4;
  localparam int CW   = 2;
  localparam int HW   = 2;
  localparam int SIZE = 16;
  localparam int CMAX = 3;
  localparam int HALF = 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          en_i;
  logic          is_branch_i;
  logic [IW-1:0] index_i;
  logic          update_en_i;
  logic          last_taken_i;
  logic          fallback_i;
  logic          taken_o;
  logic          hit_o;
  logic [HW-1:0] ghr_o;

  int m_ctr [SIZE];
  bit m_valid [SIZE];
  int m_ghr;
  int m_last;
  int checks   = 0;
  int failures = 0;
  bit checking = 1'b0;

  gshare_pht #(
    .INDEX_WIDTH(IW),
    .CTR_WIDTH  (CW),
    .HIST_WIDTH (HW)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (en_i),
    .is_branch_i (is_branch_i),
    .index_i     (index_i),
    .update_en_i (update_en_i),
    .last_taken_i(last_taken_i),
    .fallback_i  (fallback_i),
    .taken_o     (taken_o),
    .hit_o       (hit_o),
    .ghr_o       (ghr_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic int lookupOf(int idx, int g);
`ifdef PHT_GSHARE_EN
    return (idx ^ g) % SIZE;
`else
    return idx + 0 * g;
`endif
  endfunction

  // XOR hashing is self-inverse, so the same mapping finds the fetch index reaching a target entry.
  function automatic int invLookup(int target);
    return lookupOf(target, m_ghr);
  endfunction

  task automatic clearModel();
    for (int i = 0; i < SIZE; i++) begin
      m_ctr[i]   = 0;
      m_valid[i] = 1'b0;
    end
    m_ghr  = 0;
    m_last = 0;
  endtask

  task automatic stepModel();
    int li;
    int old;
    li  = lookupOf(int'(index_i), m_ghr);
    old = m_ctr[m_last];
    if (is_branch_i && !m_valid[li]) begin
      m_valid[li] = 1'b1;
      m_ctr[li]   = fallback_i ? HALF : HALF - 1;
    end
    if (update_en_i) begin
      m_ctr[m_last] = last_taken_i ? ((old < CMAX) ? old + 1 : CMAX)
                                   : ((old > 0) ? old - 1 : 0);
      m_ghr = ((m_ghr * 2) + int'(last_taken_i)) % (1 << HW);
    end
    m_last = li;
  endtask

  task automatic applyStimulus(input bit rst, input bit en, input bit br, input int idx,
                               input bit upd, input bit lt, input bit fb);
    rst_i        = rst;
    en_i         = en;
    is_branch_i  = br;
    index_i      = IW'(idx);
    update_en_i  = upd;
    last_taken_i = lt;
    fallback_i   = fb;
    if (rst) clearModel();
    @(posedge clk_i);
    if (!rst_i && en_i) stepModel();
    #1;
  endtask

  task automatic checkLiteral(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    int li;
    int exp_hit;
    int exp_taken;
    li        = lookupOf(int'(index_i), m_ghr);
    exp_hit   = int'(m_valid[li]);
    exp_taken = (exp_hit != 0) ? int'(m_ctr[li] >= HALF) : int'(fallback_i);
    checkLiteral("hit_o", int'(hit_o), exp_hit);
    checkLiteral("taken_o", int'(taken_o), exp_taken);
    checkLiteral("ghr_o", int'(ghr_o), m_ghr);
  endtask

  always @(negedge clk_i) begin
    if (checking) checkOutput();
  end

  initial begin
    int downs [3];
    downs = '{2, 1, 0};
    rst_i = 1'b1; en_i = 1'b0; is_branch_i = 1'b0; index_i = '0;
    update_en_i = 1'b0; last_taken_i = 1'b0; fallback_i = 1'b0;
    clearModel();
    checking = 1'b1;

    #1;
    checkLiteral("reset_hit", int'(hit_o), 0);
    checkLiteral("reset_ghr", int'(ghr_o), 0);
    fallback_i = 1'b1;
    #1;
    checkLiteral("reset_taken_fallback", int'(taken_o), 1);
    applyStimulus(1, 1, 1, 5, 1, 1, 0);
    applyStimulus(1, 1, 1, 9, 1, 0, 1);

    // Cold miss allocates entry 3 as weak-taken.
    applyStimulus(0, 1, 1, 3, 0, 0, 1);
    checkLiteral("alloc_hit", int'(hit_o), 1);
    checkLiteral("alloc_taken", int'(taken_o), 1);
    checkLiteral("alloc_ctr_model", m_ctr[3], 2);

    // Saturation at both ends while keeping the lookup on entry 3.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 1, 0, invLookup(3), 1, 1, 0);
      checkLiteral("sat_up_ctr", m_ctr[3], 3);
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 1, 0, invLookup(3), 1, 0, 0);
      checkLiteral("sat_down_ctr", m_ctr[3], downs[k]);
    end
    index_i    = IW'(invLookup(3));
    fallback_i = 1'b1;
    #1;
    checkLiteral("sat_hit", int'(hit_o), 1);
    checkLiteral("sat_taken", int'(taken_o), 0);

    // History hashing after two taken updates.
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 1, 1, 0);
    applyStimulus(0, 1, 0, 0, 1, 1, 0);
    checkLiteral("ghr_taken_taken", int'(ghr_o), 3);
`ifdef PHT_GSHARE_EN
    checkLiteral("hash_index5", lookupOf(5, m_ghr), 6);
`else
    checkLiteral("hash_index5", lookupOf(5, m_ghr), 5);
`endif

    // Allocation and update colliding on entry 7: update wins, valid set.
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 7, 0, 0, 0);
    applyStimulus(0, 1, 1, invLookup(7), 1, 1, 0);
    checkLiteral("collide_ctr_model", m_ctr[7], 1);
    checkLiteral("collide_valid_model", int'(m_valid[7]), 1);
    index_i = IW'(invLookup(7)); is_branch_i = 1'b0; update_en_i = 1'b0; fallback_i = 1'b1;
    #1;
    checkLiteral("collide_hit", int'(hit_o), 1);
    checkLiteral("collide_taken", int'(taken_o), 0);

    // Enable low: nothing may change for four cycles.
    for (int k = 0; k < 4; k++) applyStimulus(0, 0, 1, int'($urandom_range(0, SIZE - 1)), 1, 1, 1);
    checkLiteral("gate_ghr", int'(ghr_o), 1);
    index_i = IW'(invLookup(7)); fallback_i = 1'b1;
    #1;
    checkLiteral("gate_hit", int'(hit_o), 1);
    checkLiteral("gate_taken", int'(taken_o), 0);

    // Reset between clock edges takes effect without an edge.
    #1;
    rst_i = 1'b1;
    clearModel();
    #1;
    checkLiteral("async_hit", int'(hit_o), 0);
    checkLiteral("async_ghr", int'(ghr_o), 0);
    checkLiteral("async_taken", int'(taken_o), 1);

    for (int n = 0; n < 600; n++) begin
      applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 9) != 0,
                    1'($urandom_range(0, 1)), int'($urandom_range(0, SIZE - 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
    end

    checking = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
